// File: rtl/alarm_controller.sv
// Security-system core: collects keypad digits on Enter rises, checks them against
// a fixed passcode, and sequences DISARMED/EXIT/ARMED/ENTRY/ALARM with delay timers.
module alarm_controller #(
  parameter int                      CODE_LEN    = 4,
  parameter logic [2*CODE_LEN-1:0]   PASSCODE    = 8'b10_01_11_00,
  parameter int                      MAX_FAILS   = 3,
  parameter int                      EXIT_DELAY  = 25_000_000,
  parameter int                      ENTRY_DELAY = 25_000_000
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [1:0] i_Code,
  input  logic       i_Enter,
  input  logic       i_Sensor,
  output logic [2:0] o_State,
  output logic       o_Armed,
  output logic       o_Alarm,
  output logic [2:0] o_Digit_Count,
  output logic [2:0] o_Fail_Count,
  output logic       o_Code_Ok,
  output logic       o_Code_Bad
);

  localparam int CNT_MAX = (EXIT_DELAY > ENTRY_DELAY) ? EXIT_DELAY : ENTRY_DELAY;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BW      = 2 * CODE_LEN - 2;

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_t;

  state_t              r_State, w_State_Next;
  logic [CW-1:0]       r_Cnt, w_Cnt_Next;
  logic [BW-1:0]       r_Buf, w_Buf_Next;
  logic [2:0]          r_Digit_Count, w_Digit_Next;
  logic [2:0]          r_Fail_Count, w_Fail_Next;
  logic                r_Code_Ok, w_Ok_Next;
  logic                r_Code_Bad, w_Bad_Next;
  logic                r_Enter_D;

  logic [2*CODE_LEN-1:0] w_Word;
  logic                  w_Rise;
  logic                  w_Last;
  logic                  w_Good;
  logic                  w_Wrong;
  logic [2:0]            w_Fail_Inc;
  logic                  w_Max_Hit;

  // The previously captured digits sit in the upper bits of the entered word.
  assign w_Word     = {r_Buf, i_Code};
  assign w_Rise     = i_Enter & ~r_Enter_D;
  assign w_Last     = w_Rise && (r_Digit_Count == 3'(CODE_LEN - 1));
  assign w_Good     = w_Last && (w_Word == PASSCODE);
  assign w_Wrong    = w_Last && (w_Word != PASSCODE);
  assign w_Fail_Inc = (r_Fail_Count == 3'(MAX_FAILS)) ? r_Fail_Count : r_Fail_Count + 3'd1;
  assign w_Max_Hit  = w_Wrong && (w_Fail_Inc == 3'(MAX_FAILS));

  always_comb begin
    w_State_Next = r_State;
    w_Cnt_Next   = '0;
    w_Buf_Next   = r_Buf;
    w_Digit_Next = r_Digit_Count;
    w_Fail_Next  = r_Fail_Count;
    w_Ok_Next    = 1'b0;
    w_Bad_Next   = 1'b0;

    // Timer and sensor behaviour, lowest priority.
    case (r_State)
      S_EXIT: begin
        if (r_Cnt == '0) w_State_Next = S_ARMED;
        else             w_Cnt_Next   = r_Cnt - 1'b1;
      end
      S_ARMED: begin
        if (i_Sensor) begin
          w_State_Next = S_ENTRY;
          w_Cnt_Next   = CW'(ENTRY_DELAY - 1);
        end
      end
      S_ENTRY: begin
        if (r_Cnt == '0) w_State_Next = S_ALARM;
        else             w_Cnt_Next   = r_Cnt - 1'b1;
      end
      default: w_Cnt_Next = '0;
    endcase

    // Code results override timer and sensor outcomes.
    if (w_Good) begin
      w_Fail_Next = 3'd0;
      w_Ok_Next   = 1'b1;
      if (r_State == S_DISARMED) begin
        w_State_Next = S_EXIT;
        w_Cnt_Next   = CW'(EXIT_DELAY - 1);
      end else begin
        w_State_Next = S_DISARMED;
        w_Cnt_Next   = '0;
      end
    end else if (w_Wrong) begin
      w_Fail_Next = w_Fail_Inc;
      w_Bad_Next  = 1'b1;
      if (w_Max_Hit) begin
        w_State_Next = S_ALARM;
        w_Cnt_Next   = '0;
      end
    end

    if (w_Last) begin
      w_Digit_Next = 3'd0;
      w_Buf_Next   = '0;
    end else if (w_Rise) begin
      w_Digit_Next = r_Digit_Count + 3'd1;
      w_Buf_Next   = w_Word[BW-1:0];
    end
  end

  // Enter history resets high so a button held through reset is not a press.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_State       <= S_DISARMED;
      r_Cnt         <= '0;
      r_Buf         <= '0;
      r_Digit_Count <= 3'd0;
      r_Fail_Count  <= 3'd0;
      r_Code_Ok     <= 1'b0;
      r_Code_Bad    <= 1'b0;
      r_Enter_D     <= 1'b1;
    end else begin
      r_State       <= w_State_Next;
      r_Cnt         <= w_Cnt_Next;
      r_Buf         <= w_Buf_Next;
      r_Digit_Count <= w_Digit_Next;
      r_Fail_Count  <= w_Fail_Next;
      r_Code_Ok     <= w_Ok_Next;
      r_Code_Bad    <= w_Bad_Next;
      r_Enter_D     <= i_Enter;
    end
  end

  assign o_State       = r_State;
  assign o_Armed       = (r_State == S_ARMED) || (r_State == S_ENTRY);
  assign o_Alarm       = (r_State == S_ALARM);
  assign o_Digit_Count = r_Digit_Count;
  assign o_Fail_Count  = r_Fail_Count;
  assign o_Code_Ok     = r_Code_Ok;
  assign o_Code_Bad    = r_Code_Bad;

endmodule
